// File: rtl/matrix_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_stream_loader
//  Purpose  : Parses a byte stream of decimal tokens into matrix dimensions
//             and elements (or generates pseudo-random matrices) and writes
//             them to memory at an allocated base address.
//  Revision : 1.0  initial release
// ============================================================================
module matrix_stream_loader #(
   parameter int DIM_MAX   = 5,
   parameter int ELEM_MAX  = 9,
   parameter int SIGNED_EN = 0,
   parameter int GEN_MAX   = 2,
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 25_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              gen_mode,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              addr_ready,
   input  logic              wr_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [2:0]        dim_m,
   output logic [2:0]        dim_n,
   output logic              dims_valid,
   output logic              done,
   output logic              err,
   output logic [2:0]        err_code
);

   localparam logic [31:0] DIM_LIM  = 32'(DIM_MAX);
   localparam logic [31:0] ELEM_LIM = 32'(ELEM_MAX);
   localparam logic [31:0] GEN_LIM  = 32'(GEN_MAX);
   localparam logic [31:0] ELEM_MOD = 32'(ELEM_MAX + 1);
   localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      RX_M, RX_N, RX_CNT, WAIT_ADDR, CLEAR, USER, GEN, FLUSH, DONE
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         acc_q, acc_d;
   logic                have_q, have_d;
   logic                neg_q, neg_d;
   logic [2:0]          dim_m_q, dim_m_d, dim_n_q, dim_n_d;
   logic                gen_q, gen_d;
   logic [7:0]          cnt_total_q, cnt_total_d, gen_cnt_q, gen_cnt_d;
   logic [ADDR_W-1:0]   index_q, index_d, base_q, base_d;
   logic                wr_en_q, wr_en_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                err_q, err_d;
   logic [2:0]          code_q, code_d;
   logic [31:0]         idle_q, idle_d;
   logic [31:0]         lfsr_q;

   // byte classification and derived conditions
   logic              is_digit, is_crlf, is_delim, is_minus;
   logic              parsing, minus_ok, bad_char, tok_done, accept;
   logic              idle_run, timeout_hit;
   logic [31:0]       sat_lim, acc_next, acc_sat, rand_val;
   logic [5:0]        total;
   logic [ADDR_W-1:0] last_idx;
   logic [DATA_W-1:0] elem_val, rand_data;

   assign is_digit    = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_crlf     = (rx_data == 8'h0D) || (rx_data == 8'h0A);
   assign is_delim    = is_crlf || (rx_data == 8'h20);
   assign is_minus    = (rx_data == 8'h2D);
   assign parsing     = (state_q == RX_M) || (state_q == RX_N) ||
                        (state_q == RX_CNT) || (state_q == USER);
   assign minus_ok    = is_minus && (SIGNED_EN != 0) && (state_q == USER) &&
                        !have_q && !neg_q;
   assign bad_char    = parsing && rx_valid && !is_digit && !is_delim && !minus_ok;
   assign tok_done    = parsing && rx_valid && is_delim && have_q;
   assign accept      = wr_en_q && wr_ready;
   assign idle_run    = !rx_valid && ((state_q == USER) || (state_q == FLUSH));
   assign timeout_hit = idle_run && (idle_q == TO_LAST);
   assign acc_next    = acc_q * 32'd10 + {28'd0, rx_data[3:0]};
   assign acc_sat     = (acc_next > sat_lim) ? sat_lim : acc_next;
   assign total       = {3'd0, dim_m_q} * {3'd0, dim_n_q};
   assign last_idx    = ADDR_W'(total) - ADDR_W'(1);
   assign rand_val    = lfsr_q % ELEM_MOD;
   assign rand_data   = DATA_W'(rand_val);
   assign elem_val    = neg_q ? (DATA_W'(0) - DATA_W'(acc_q)) : DATA_W'(acc_q);

   // accumulator saturation point depends on what the token is being parsed as
   always_comb begin
      sat_lim = DIM_LIM + 32'd1;
      if (state_q == USER)
         sat_lim = ELEM_LIM + 32'd1;
      else if (state_q == RX_CNT)
         sat_lim = GEN_LIM + 32'd1;
   end

   // next-state and datapath update; en low folds everything back to the reset image
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      have_d      = have_q;
      neg_d       = neg_q;
      dim_m_d     = dim_m_q;
      dim_n_d     = dim_n_q;
      gen_d       = gen_q;
      cnt_total_d = cnt_total_q;
      gen_cnt_d   = gen_cnt_q;
      index_d     = index_q;
      base_d      = base_q;
      wr_en_d     = wr_en_q;
      wr_data_d   = wr_data_q;
      err_d       = err_q;
      code_d      = code_q;
      idle_d      = idle_run ? idle_q + 32'd1 : 32'd0;

      if (accept) begin
         index_d = index_q + ADDR_W'(1);
         wr_en_d = 1'b0;
      end

      if (parsing && rx_valid) begin
         if (is_digit) begin
            acc_d  = acc_sat;
            have_d = 1'b1;
            err_d  = 1'b0;
            code_d = 3'd0;
         end else if (minus_ok) begin
            neg_d = 1'b1;
         end else begin
            acc_d  = 32'd0;
            have_d = 1'b0;
            neg_d  = 1'b0;
         end
      end

      case (state_q)
         RX_M: if (tok_done) begin
            if (acc_q >= 32'd1 && acc_q <= DIM_LIM) begin
               dim_m_d = acc_q[2:0];
               state_d = RX_N;
            end else begin
               err_d  = 1'b1;
               code_d = 3'd1;
               if (is_crlf) state_d = RX_M;
               else         state_d = FLUSH;
            end
         end
         RX_N: if (tok_done) begin
            if (acc_q >= 32'd1 && acc_q <= DIM_LIM) begin
               dim_n_d = acc_q[2:0];
               gen_d   = gen_mode;
               if (gen_mode) state_d = RX_CNT;
               else          state_d = WAIT_ADDR;
            end else begin
               err_d  = 1'b1;
               code_d = 3'd1;
               if (is_crlf) state_d = RX_M;
               else         state_d = FLUSH;
            end
         end
         RX_CNT: if (tok_done) begin
            if (acc_q >= 32'd1 && acc_q <= GEN_LIM) begin
               cnt_total_d = acc_q[7:0];
               gen_cnt_d   = 8'd0;
               state_d     = WAIT_ADDR;
            end else begin
               err_d  = 1'b1;
               code_d = 3'd5;
               if (is_crlf) state_d = RX_M;
               else         state_d = FLUSH;
            end
         end
         WAIT_ADDR: if (addr_ready) begin
            base_d  = base_addr;
            index_d = '0;
            wr_en_d = 1'b1;
            if (gen_q) begin
               state_d   = GEN;
               wr_data_d = rand_data;
            end else begin
               state_d   = CLEAR;
               wr_data_d = '0;
            end
         end
         CLEAR: if (accept) begin
            if (index_q == last_idx) begin
               state_d = USER;
               index_d = '0;
            end else begin
               wr_en_d = 1'b1;
            end
         end
         USER: begin
            if (accept && index_q == last_idx) begin
               state_d = DONE;
            end else if (tok_done) begin
               if (acc_q > ELEM_LIM) begin
                  err_d  = 1'b1;
                  code_d = 3'd2;
               end else if (wr_en_q && !wr_ready) begin
                  err_d  = 1'b1;
                  code_d = 3'd4;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_data_d = elem_val;
                  if (is_crlf) state_d = DONE;
               end
            end else if (rx_valid && is_crlf && !have_q && !err_q) begin
               state_d = DONE;
            end else if (timeout_hit) begin
               state_d = DONE;
            end
         end
         GEN: if (accept) begin
            if (index_q == last_idx) begin
               gen_cnt_d = gen_cnt_q + 8'd1;
               index_d   = '0;
               if (gen_cnt_q + 8'd1 < cnt_total_q) state_d = WAIT_ADDR;
               else                                state_d = DONE;
            end else begin
               wr_en_d   = 1'b1;
               wr_data_d = rand_data;
            end
         end
         FLUSH: begin
            acc_d  = 32'd0;
            have_d = 1'b0;
            neg_d  = 1'b0;
            err_d  = 1'b1;
            if ((rx_valid && is_crlf) || timeout_hit) state_d = RX_M;
         end
         default: ;
      endcase

      // an illegal byte overrides whatever the state logic decided
      if (bad_char) begin
         err_d   = 1'b1;
         code_d  = 3'd3;
         state_d = FLUSH;
      end

      if (!en) begin
         state_d     = RX_M;
         acc_d       = 32'd0;
         have_d      = 1'b0;
         neg_d       = 1'b0;
         dim_m_d     = 3'd0;
         dim_n_d     = 3'd0;
         gen_d       = 1'b0;
         cnt_total_d = 8'd0;
         gen_cnt_d   = 8'd0;
         index_d     = '0;
         base_d      = '0;
         wr_en_d     = 1'b0;
         wr_data_d   = '0;
         err_d       = 1'b0;
         code_d      = 3'd0;
         idle_d      = 32'd0;
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RX_M;
         acc_q       <= 32'd0;
         have_q      <= 1'b0;
         neg_q       <= 1'b0;
         dim_m_q     <= 3'd0;
         dim_n_q     <= 3'd0;
         gen_q       <= 1'b0;
         cnt_total_q <= 8'd0;
         gen_cnt_q   <= 8'd0;
         index_q     <= '0;
         base_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= '0;
         err_q       <= 1'b0;
         code_q      <= 3'd0;
         idle_q      <= 32'd0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         have_q      <= have_d;
         neg_q       <= neg_d;
         dim_m_q     <= dim_m_d;
         dim_n_q     <= dim_n_d;
         gen_q       <= gen_d;
         cnt_total_q <= cnt_total_d;
         gen_cnt_q   <= gen_cnt_d;
         index_q     <= index_d;
         base_q      <= base_d;
         wr_en_q     <= wr_en_d;
         wr_data_q   <= wr_data_d;
         err_q       <= err_d;
         code_q      <= code_d;
         idle_q      <= idle_d;
      end
   end

   // free-running LFSR, deliberately independent of en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= 32'h0000_ACE1;
      else        lfsr_q <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1]};
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = base_q + index_q;
   assign wr_data    = wr_data_q;
   assign dim_m      = dim_m_q;
   assign dim_n      = dim_n_q;
   assign dims_valid = (state_q == WAIT_ADDR);
   assign done       = (state_q == DONE);
   assign err        = err_q;
   assign err_code   = code_q;

endmodule
`default_nettype wire
